aes_round_ctrl: RTL and testbench
=================================

# aes_round_ctrl

Parametrised control FSM for the AES core. It sequences key expansion into the round-key store, then either encryption or decryption, for AES-128, AES-192 or AES-256. Block acceptance uses a start/ready handshake and result delivery uses a valid/ready handshake. It drives only select and enable strobes into the existing datapath (state register, round unit, key store), and no data.

## Interface
- `NK`, default 4: key length in 32-bit words; legal values 4, 6, 8. Round count `NR = NK + 6`.
- `SLOT_W`, default 4: width of the round-key slot index; must satisfy `2**SLOT_W > NR`.
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request to process one block; accepted when `start && in_ready`.
- `mode`  in  1: sampled at acceptance; 1 = encrypt, 0 = decrypt.
- `key_load`  in  1: sampled at acceptance; 1 = expand a new key before processing.
- `out_ready`  in  1: downstream accepts result.
- `in_ready`  out  1: FSM idle and able to accept.
- `busy`  out  1: any state other than IDLE.
- `key_we`  out  1: write the round-key store at `key_slot`.
- `key_first`  out  1: key store input = raw key (slot 0); otherwise key-generator output.
- `key_slot`  out  SLOT_W: round-key slot read/written this cycle.
- `st_load`  out  1: load the state register.
- `st_src`  out  1: 0 = input block, 1 = round-unit feedback.
- `last_rnd`  out  1: round unit skips MixColumns/InvMixColumns.
- `ark_only`  out  1: round unit performs AddRoundKey only.
- `out_valid`  out  1: result stable on datapath output.
- `err`  out  1: one-cycle pulse for an illegal start.

## Operation
- States: IDLE, KEY_FIRST, KEY_EXP, ARK, ROUND, LAST, DONE.
- Internal registers:
  - `rnd`: 0..NR round counter.
  - `mode_q`: latched mode.
  - `key_valid`: set after the last KEY_EXP; cleared only by reset.
- IDLE: `in_ready=1`. When `start` is asserted:
  - `key_load=1`: go to KEY_FIRST.
  - `key_load=0` and `key_valid=1`: go to ARK.
  - `key_load=0` and `key_valid=0`: pulse `err`, stay in IDLE.
- KEY_FIRST: `key_we=1`, `key_first=1`, `key_slot=0`. Set `rnd=1` and go to KEY_EXP.
- KEY_EXP: `key_we=1`, `key_slot=rnd`. Increment `rnd`. Leave to ARK when `rnd==NR`.
- ARK: `st_load=1`, `st_src=0`, `ark_only=1`. `key_slot` is 0 for encrypt, NR for decrypt. Set `rnd=1`.
- ROUND: `st_load=1`, `st_src=1`. `key_slot` is `rnd` for encrypt, `NR-rnd` for decrypt. Increment `rnd`. Leave to LAST when `rnd==NR-1`.
- LAST: `st_load=1`, `st_src=1`, `last_rnd=1`. `key_slot` is NR for encrypt, 0 for decrypt. Go to DONE.
- DONE: `out_valid=1`, held until `out_ready`, then return to IDLE. `in_ready` stays 0 in DONE, so there is no overlap with the next block.
- `start` outside IDLE is ignored: no error, no queuing.
- All outputs are decoded from registered state and counter (Moore outputs). Unused strobes are 0.
- Illegal or unreachable state encoding returns to IDLE.

## Timing
- Reset values: every output is 0 except `in_ready=1`. State is IDLE, `rnd=0`, `key_valid=0`.
- Reset assertion mid-operation: immediate return to IDLE. `key_valid` is cleared, so a key reload is required.
- Acceptance at cycle 0 gives `out_valid` at these cycles:
  - Without key load: cycle NR+2 (12, 14 or 16 for NK = 4, 6, 8).
  - With key load: cycle 2·NR+3.
- Minimum acceptance-to-acceptance interval without key load is NR+3 cycles. This assumes `out_ready` is held high.
- `err` asserts in the cycle after the rejected `start`.

## Configuration
- `AES_CTRL_ABORT_EN` defined:
  - Adds input `abort` (1 bit).
  - `abort` seen in any busy state forces IDLE on the next edge and drops `out_valid`.
  - An abort during KEY_FIRST or KEY_EXP also clears `key_valid`.
  - An abort during ARK, ROUND, LAST or DONE keeps `key_valid`.
  - `abort` in IDLE has no effect. `abort` takes priority over `out_ready`.
- `AES_CTRL_ABORT_EN` undefined: the port does not exist, and every accepted block runs to DONE.

## Structure
- Package `aes_ctrl_pkg` holds:
  - The `aes_ctrl_state_t` enum.
  - The `aes_nr(NK)` constant function.
  - Localparams for legal NK values.
  - An elaboration-time check rejecting illegal NK or SLOT_W.
- Sub-module `aes_key_slot_map`: combinational mapping (state, `rnd`, `mode_q`, NR) → `key_slot`. Shared with future pipelined variants.

## Test plan
- Reset, then `start=1`, `key_load=0` → `err` pulse, `in_ready` stays 1, no `key_we`.
- NK=4, `start` with `key_load=1`, `mode=1` → `key_we` on slots 0..10 in cycles 1..11; `ark_only` at cycle 12 with slot 0; `last_rnd` with slot 10; `out_valid` at cycle 23.
- NK=4, decrypt with no key load → ROUND slots 9,8,…,1; LAST slot 0; `out_valid` at cycle 12.
- NK=8 encrypt → ROUND slots 1..13, LAST slot 14, `out_valid` at cycle 16; NK=6 encrypt → `out_valid` at cycle 14.
- `out_ready` held 0 for 5 cycles in DONE → `out_valid` held and `start` ignored; `out_ready=1` → IDLE the next cycle.
- With `AES_CTRL_ABORT_EN`, `abort` in ROUND then `start`/`key_load=0` → IDLE, then a normal run (`key_valid` kept). `abort` during KEY_EXP, then the same `start` → `err`.

Source files
------------

// File: rtl/aes_round_ctrl_pkg.sv
// aes_ctrl_pkg: shared types and helpers for the AES round controller.
// FSM state enum, round-count function, legal key sizes, config check.
package aes_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY_FIRST,
    ST_KEY_EXP,
    ST_ARK,
    ST_ROUND,
    ST_LAST,
    ST_DONE
  } aes_ctrl_state_t;

  localparam int NK_AES128 = 4;
  localparam int NK_AES192 = 6;
  localparam int NK_AES256 = 8;

  function automatic int aes_nr(input int nk);
    return nk + 6;
  endfunction

  function automatic bit aes_cfg_ok(
    input int nk,
    input int slot_w
  );
    bit nk_ok;
    nk_ok = (nk == NK_AES128) ||
            (nk == NK_AES192) ||
            (nk == NK_AES256);
    if (slot_w < 1 || slot_w > 30) return 1'b0;
    return nk_ok && ((1 << slot_w) > aes_nr(nk));
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if: handshake + datapath strobe bundle of the AES controller.
// master = block driving start/out_ready, slave = the controller.
// With AES_CTRL_ABORT_EN defined an abort input is added.
interface aes_round_ctrl_if #(
  parameter int SLOT_W = 4
);
  logic              start;
  logic              mode;
  logic              key_load;
  logic              out_ready;
`ifdef AES_CTRL_ABORT_EN
  logic              abort;
`endif
  logic              in_ready;
  logic              busy;
  logic              key_we;
  logic              key_first;
  logic [SLOT_W-1:0] key_slot;
  logic              st_load;
  logic              st_src;
  logic              last_rnd;
  logic              ark_only;
  logic              out_valid;
  logic              err;

  modport master (
`ifdef AES_CTRL_ABORT_EN
    output abort,
`endif
    output start, mode, key_load, out_ready,
    input  in_ready, busy, key_we, key_first,
    input  key_slot, st_load, st_src, last_rnd,
    input  ark_only, out_valid, err
  );

  modport slave (
`ifdef AES_CTRL_ABORT_EN
    input  abort,
`endif
    input  start, mode, key_load, out_ready,
    output in_ready, busy, key_we, key_first,
    output key_slot, st_load, st_src, last_rnd,
    output ark_only, out_valid, err
  );

endinterface

// File: rtl/aes_round_ctrl_key_slot_map.sv
// aes_key_slot_map: round-key slot select from state, rnd, mode, NR.
// Ports: st_i, rnd_i, mode_i (1=enc), nr_i in; slot_o out.
module aes_key_slot_map
  import aes_ctrl_pkg::*;
#(
  parameter int SLOT_W = 4
) (
  input  aes_ctrl_state_t   st_i,
  input  logic [SLOT_W-1:0] rnd_i,
  input  logic              mode_i,
  input  logic [SLOT_W-1:0] nr_i,
  output logic [SLOT_W-1:0] slot_o
);

  always_comb begin
    slot_o = '0;
    unique case (1'b1)
      (st_i == ST_KEY_EXP):
        slot_o = rnd_i;
      (st_i == ST_ARK):
        slot_o = mode_i ? '0 : nr_i;
      // decrypt walks the schedule backwards
      (st_i == ST_ROUND):
        slot_o = mode_i ? rnd_i : nr_i - rnd_i;
      (st_i == ST_LAST):
        slot_o = mode_i ? nr_i : '0;
      default:
        slot_o = '0;
    endcase
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: key-expansion / encrypt / decrypt sequencer for AES.
// Ports: clk, reset_n (async low), io (aes_round_ctrl_if.slave).
// Optional AES_CTRL_ABORT_EN adds io.abort to cancel a busy block.
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NK     = 4,
  parameter int SLOT_W = 4
) (
  input logic             clk,
  input logic             reset_n,
  aes_round_ctrl_if.slave io
);

  localparam int NR = aes_nr(NK);
  localparam logic [SLOT_W-1:0] NR_S  = SLOT_W'(NR);
  localparam logic [SLOT_W-1:0] NR_M1 = SLOT_W'(NR - 1);
  localparam logic [SLOT_W-1:0] ONE   = SLOT_W'(1);

  if (!aes_cfg_ok(NK, SLOT_W)) begin : g_cfg_err
    $error("aes_round_ctrl: illegal NK or SLOT_W");
  end

  aes_ctrl_state_t   state_q, state_d;
  logic [SLOT_W-1:0] rnd_q, rnd_d;
  logic              mode_q, mode_d;
  logic              key_valid_q, key_valid_d;
  logic              err_q, err_d;
  logic              abort_w;

`ifdef AES_CTRL_ABORT_EN
  assign abort_w = io.abort;
`else
  assign abort_w = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rnd_q       <= '0;
      mode_q      <= 1'b0;
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      mode_q      <= mode_d;
      key_valid_q <= key_valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    mode_d      = mode_q;
    key_valid_d = key_valid_q;
    err_d       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (io.start) begin
          mode_d = io.mode;
          if (io.key_load)
            state_d = ST_KEY_FIRST;
          else if (key_valid_q)
            state_d = ST_ARK;
          else
            err_d = 1'b1;
        end
      end
      ST_KEY_FIRST: begin
        rnd_d   = ONE;
        state_d = ST_KEY_EXP;
      end
      ST_KEY_EXP: begin
        rnd_d = rnd_q + ONE;
        if (rnd_q == NR_S) begin
          state_d     = ST_ARK;
          key_valid_d = 1'b1;
        end
      end
      ST_ARK: begin
        rnd_d   = ONE;
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        rnd_d = rnd_q + ONE;
        if (rnd_q == NR_M1)
          state_d = ST_LAST;
      end
      ST_LAST:
        state_d = ST_DONE;
      ST_DONE:
        if (io.out_ready)
          state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
    // a half-written key store cannot be trusted after abort
    if (abort_w && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      if (state_q == ST_KEY_FIRST || state_q == ST_KEY_EXP)
        key_valid_d = 1'b0;
    end
  end

  always_comb begin
    io.in_ready  = (state_q == ST_IDLE);
    io.busy      = (state_q != ST_IDLE);
    io.key_we    = (state_q == ST_KEY_FIRST) ||
                   (state_q == ST_KEY_EXP);
    io.key_first = (state_q == ST_KEY_FIRST);
    io.st_load   = (state_q == ST_ARK) ||
                   (state_q == ST_ROUND) ||
                   (state_q == ST_LAST);
    io.st_src    = (state_q == ST_ROUND) ||
                   (state_q == ST_LAST);
    io.last_rnd  = (state_q == ST_LAST);
    io.ark_only  = (state_q == ST_ARK);
    io.out_valid = (state_q == ST_DONE);
    io.err       = err_q;
  end

  aes_key_slot_map #(
    .SLOT_W(SLOT_W)
  ) u_slot_map (
    .st_i  (state_q),
    .rnd_i (rnd_q),
    .mode_i(mode_q),
    .nr_i  (NR_S),
    .slot_o(io.key_slot)
  );

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: randomized schedule-level checks of aes_round_ctrl.
// Three DUTs (NK=4,6,8) share clk/reset_n; AES_CTRL_ABORT_EN adds abort tests.
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_round_ctrl_if if4 ();
  aes_round_ctrl_if if6 ();
  aes_round_ctrl_if if8 ();

  aes_round_ctrl #(.NK(4), .SLOT_W(4)) u4 (
    .clk(clk), .reset_n(reset_n), .io(if4.slave));
  aes_round_ctrl #(.NK(6), .SLOT_W(4)) u6 (
    .clk(clk), .reset_n(reset_n), .io(if6.slave));
  aes_round_ctrl #(.NK(8), .SLOT_W(4)) u8 (
    .clk(clk), .reset_n(reset_n), .io(if8.slave));

  // {in_ready,busy,key_we,key_first,slot[3:0],
  //  st_load,st_src,last_rnd,ark_only,out_valid,err}
  function automatic logic [13:0] sample(
    virtual aes_round_ctrl_if v);
    return {v.in_ready, v.busy, v.key_we, v.key_first,
            v.key_slot, v.st_load, v.st_src, v.last_rnd,
            v.ark_only, v.out_valid, v.err};
  endfunction

  function automatic logic [13:0] mk(
    bit ir, bit bz, bit we, bit kf, int slot,
    bit sl, bit ss, bit lr, bit ao, bit ov, bit er);
    logic [3:0] s4;
    s4 = slot[3:0];
    return {ir, bz, we, kf, s4, sl, ss, lr, ao, ov, er};
  endfunction

  localparam logic [13:0] IDLE_V = 14'b10_0000_0000_0000;
  localparam logic [13:0] ERR_V  = 14'b10_0000_0000_0001;

  task automatic init_if(virtual aes_round_ctrl_if v);
    v.start     = 1'b0;
    v.mode      = 1'b0;
    v.key_load  = 1'b0;
    v.out_ready = 1'b1;
`ifdef AES_CTRL_ABORT_EN
    v.abort     = 1'b0;
`endif
  endtask

  // Called at a negedge with the DUT idle; returns at the
  // negedge of the first idle cycle after the block.
  task automatic run_block(
    input  virtual aes_round_ctrl_if v,
    input  int    nr,
    input  bit    kl,
    input  bit    md,
    input  int    stall,
    input  string tag,
    output int    acc_cyc);
    logic [13:0] q[$];
    logic [13:0] got;
    int first_ov;
    int base;
    if (kl)
      for (int s = 0; s <= nr; s++)
        q.push_back(mk(0,1,1,s==0,s,0,0,0,0,0,0));
    q.push_back(mk(0,1,0,0,md ? 0 : nr,1,0,0,1,0,0));
    for (int r = 1; r < nr; r++)
      q.push_back(mk(0,1,0,0,md ? r : nr-r,1,1,0,0,0,0));
    q.push_back(mk(0,1,0,0,md ? nr : 0,1,1,1,0,0,0));
    for (int j = 0; j <= stall; j++)
      q.push_back(mk(0,1,0,0,0,0,0,0,0,1,0));
    q.push_back(IDLE_V);
    base = q.size() - 2 - stall;

    acc_cyc    = cyc;
    v.start    = 1'b1;
    v.mode     = md;
    v.key_load = kl;
    v.out_ready = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    v.start = 1'b0;
    first_ov = -1;
    for (int k = 0; k < q.size(); k++) begin
      if (k > 0) @(negedge clk);
      got = sample(v);
      total++;
      if (got !== q[k]) begin
        bad++;
        $display("FAIL %s cycle %0d got=%b want=%b",
                 tag, k + 1, got, q[k]);
      end
      if (got[1] === 1'b1 && first_ov < 0)
        first_ov = k + 1;
      if (k >= base && k < base + stall) begin
        v.start     = 1'b1;
        v.mode      = 1'($urandom);
        v.key_load  = 1'($urandom);
        v.out_ready = 1'b0;
      end else if (k == base + stall) begin
        v.start     = 1'b0;
        v.out_ready = 1'b1;
      end
    end
    total++;
    if (first_ov != (kl ? 2*nr + 3 : nr + 2)) begin
      bad++;
      $display("FAIL %s latency got=%0d want=%0d",
               tag, first_ov, kl ? 2*nr + 3 : nr + 2);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (sample(if4) !== IDLE_V) begin
      bad++;
      $display("FAIL reset4 got=%b want=%b", sample(if4), IDLE_V);
    end
    total++;
    if (sample(if6) !== IDLE_V) begin
      bad++;
      $display("FAIL reset6 got=%b want=%b", sample(if6), IDLE_V);
    end
    total++;
    if (sample(if8) !== IDLE_V) begin
      bad++;
      $display("FAIL reset8 got=%b want=%b", sample(if8), IDLE_V);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_err();
    logic [13:0] got;
    if4.start    = 1'b1;
    if4.key_load = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if4.start = 1'b0;
    got = sample(if4);
    total++;
    if (got !== ERR_V) begin
      bad++;
      $display("FAIL err_pulse got=%b want=%b", got, ERR_V);
    end
    @(negedge clk);
    got = sample(if4);
    total++;
    if (got !== IDLE_V) begin
      bad++;
      $display("FAIL err_clear got=%b want=%b", got, IDLE_V);
    end
  endtask

  task automatic test_enc_dec();
    int a;
    run_block(if4, 10, 1'b1, 1'b1, 0, "enc128_kl", a);
    run_block(if4, 10, 1'b0, 1'b0, 0, "dec128", a);
  endtask

  task automatic test_nk68();
    int a;
    run_block(if8, 14, 1'b1, 1'b1, 0, "enc256_kl", a);
    run_block(if8, 14, 1'b0, 1'b1, 0, "enc256", a);
    run_block(if6, 12, 1'b1, 1'b0, 0, "dec192_kl", a);
    run_block(if6, 12, 1'b0, 1'b1, 0, "enc192", a);
  endtask

  task automatic test_stall();
    int a;
    run_block(if4, 10, 1'b0, 1'b1, 5, "stall", a);
  endtask

  task automatic test_back_to_back();
    int a1;
    int a2;
    run_block(if4, 10, 1'b0, 1'b1, 0, "b2b_a", a1);
    run_block(if4, 10, 1'b0, 1'b0, 0, "b2b_b", a2);
    total++;
    if (a2 - a1 != 13) begin
      bad++;
      $display("FAIL b2b_interval got=%0d want=13", a2 - a1);
    end
  endtask

  task automatic test_random();
    int a;
    bit kl;
    bit md;
    int st;
    for (int i = 0; i < 8; i++) begin
      kl = ($urandom % 4) == 0;
      md = 1'($urandom);
      st = $urandom_range(0, 3);
      run_block(if4, 10, kl, md, st, "rand", a);
    end
  endtask

`ifdef AES_CTRL_ABORT_EN
  task automatic test_abort();
    logic [13:0] got;
    int a;
    if4.start    = 1'b1;
    if4.key_load = 1'b0;
    if4.mode     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if4.start = 1'b0;
    @(negedge clk);
    if4.abort = 1'b1;
    @(negedge clk);
    if4.abort = 1'b0;
    got = sample(if4);
    total++;
    if (got !== IDLE_V) begin
      bad++;
      $display("FAIL abort_round got=%b want=%b", got, IDLE_V);
    end
    run_block(if4, 10, 1'b0, 1'b1, 0, "post_abort", a);
    if4.start    = 1'b1;
    if4.key_load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if4.start = 1'b0;
    @(negedge clk);
    if4.abort = 1'b1;
    @(negedge clk);
    if4.abort = 1'b0;
    got = sample(if4);
    total++;
    if (got !== IDLE_V) begin
      bad++;
      $display("FAIL abort_kexp got=%b want=%b", got, IDLE_V);
    end
    if4.start    = 1'b1;
    if4.key_load = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if4.start = 1'b0;
    got = sample(if4);
    total++;
    if (got !== ERR_V) begin
      bad++;
      $display("FAIL abort_keyinv got=%b want=%b", got, ERR_V);
    end
    @(negedge clk);
    run_block(if4, 10, 1'b1, 1'b1, 0, "reload", a);
  endtask
`endif

  task automatic test_reset_midop();
    logic [13:0] got;
    if4.start    = 1'b1;
    if4.key_load = 1'b0;
    if4.mode     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if4.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 got = sample(if4);
    total++;
    if (got !== IDLE_V) begin
      bad++;
      $display("FAIL reset_midop got=%b want=%b", got, IDLE_V);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    if4.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if4.start = 1'b0;
    got = sample(if4);
    total++;
    if (got !== ERR_V) begin
      bad++;
      $display("FAIL reset_keyinv got=%b want=%b", got, ERR_V);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    init_if(if4);
    init_if(if6);
    init_if(if8);
    test_reset();
    test_err();
    test_enc_dec();
    test_nk68();
    test_stall();
    test_back_to_back();
    test_random();
`ifdef AES_CTRL_ABORT_EN
    test_abort();
`endif
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
